game_score_ctrl: RTL and testbench

Game-state controller for Whack-a-Mole that sits directly upstream of the seven-segment/LED display stage. It runs the IDLE/PLAY/OVER game flow and keeps a 1 Hz elapsed-time counter. It accumulates score from hit and miss pulses and derives the difficulty level. Its score, level and timer outputs feed the display digits and the 12-LED countdown bar (timer/5).

---
 rtl/game_score_ctrl_pkg.sv | 30 +++
 rtl/game_score_ctrl_sec_tick_gen.sv | 30 +++
 rtl/game_score_ctrl.sv | 102 ++++++++++
 tb/tb_game_score_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_score_ctrl_pkg.sv
// Shared game-flow encoding and default game constants for the
// score controller, display and mole generator.
package game_score_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int TICKS_PER_SEC_DEF = 100_000_000;
    localparam int GAME_SECONDS_DEF  = 60;
    localparam int SCORE_MAX_DEF     = 99;
    localparam int LVL2_SCORE_DEF    = 20;
    localparam int LVL3_SCORE_DEF    = 40;

    function automatic logic [1:0] score_level(
        input logic [9:0] s,
        input logic [9:0] l2,
        input logic [9:0] l3
    );
        if (s >= l3)
            return 2'd3;
        else if (s >= l2)
            return 2'd2;
        else
            return 2'd1;
    endfunction

endpackage

// File: rtl/game_score_ctrl_sec_tick_gen.sv
// Game-second prescaler: tick is high during the last cycle of
// each second while enabled; clear restarts the second.
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    // Decoded from registers only, so it drops with rst or enable.
    assign tick = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/game_score_ctrl.sv
// Whack-a-Mole game flow, elapsed-time counter, score and level
// registers feeding the display stage.
module game_score_ctrl
    import game_score_ctrl_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
    parameter int GAME_SECONDS  = GAME_SECONDS_DEF,
    parameter int SCORE_MAX     = SCORE_MAX_DEF,
    parameter int LVL2_SCORE    = LVL2_SCORE_DEF,
    parameter int LVL3_SCORE    = LVL3_SCORE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic [9:0] score,
    output logic [1:0] level,
    output logic [6:0] timer,
    output logic       playing,
    output logic       game_over,
    output logic       sec_tick
);

    localparam logic [9:0] SMAX = 10'(SCORE_MAX);
    localparam logic [9:0] L2   = 10'(LVL2_SCORE);
    localparam logic [9:0] L3   = 10'(LVL3_SCORE);
    localparam logic [6:0] GS   = 7'(GAME_SECONDS);

    state_t     state;
    state_t     state_d;
    logic [9:0] score_d;
    logic [1:0] level_d;
    logic [1:0] lvl_new;
    logic [6:0] timer_d;
    logic       start_acc;
    logic       tick;

    assign start_acc = start && (state != PLAY);

    sec_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (start_acc),
        .enable(playing),
        .tick  (tick)
    );

    always_comb begin
        state_d = state;
        score_d = score;
        level_d = level;
        timer_d = timer;
        lvl_new = 2'd1;
        case (state)
            IDLE, OVER: begin
                if (start) begin
                    state_d = PLAY;
                    score_d = '0;
                    timer_d = '0;
                    level_d = 2'd1;
                end
            end
            PLAY: begin
                if (hit && !miss)
                    score_d = (score >= SMAX) ? SMAX : score + 10'd1;
                else if (miss && !hit)
                    score_d = (score == '0) ? '0 : score - 10'd1;
                // Level never drops within a game.
                lvl_new = score_level(score_d, L2, L3);
                level_d = (lvl_new > level) ? lvl_new : level;
                if (tick) begin
                    timer_d = timer + 7'd1;
                    if (timer_d == GS)
                        state_d = OVER;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            score <= '0;
            level <= '0;
            timer <= '0;
        end else begin
            state <= state_d;
            score <= score_d;
            level <= level_d;
            timer <= timer_d;
        end
    end

    assign playing   = (state == PLAY);
    assign game_over = (state == OVER);
    assign sec_tick  = tick;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Randomized and directed bench for game_score_ctrl against a
// cycle-level behavioural model of the game rules.
module tb_game_score_ctrl;

    localparam int T    = 4;
    localparam int G    = 40;
    localparam int SMAX = 99;
    localparam int LV2  = 20;
    localparam int LV3  = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       hit;
    logic       miss;
    logic [9:0] score;
    logic [1:0] level;
    logic [6:0] timer;
    logic       playing;
    logic       game_over;
    logic       sec_tick;

    int checks   = 0;
    int failures = 0;

    // Model state: playing flag, over flag, cycles into game, values.
    bit m_play;
    bit m_over;
    int m_k;
    int m_score;
    int m_level;
    int m_timer;

    game_score_ctrl #(
        .TICKS_PER_SEC(T),
        .GAME_SECONDS (G),
        .SCORE_MAX    (SMAX),
        .LVL2_SCORE   (LV2),
        .LVL3_SCORE   (LV3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .hit      (hit),
        .miss     (miss),
        .score    (score),
        .level    (level),
        .timer    (timer),
        .playing  (playing),
        .game_over(game_over),
        .sec_tick (sec_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lvl_of(input int s);
        if (s >= LV3) return 3;
        if (s >= LV2) return 2;
        return 1;
    endfunction

    function automatic bit m_tick();
        return m_play && (m_k % T == T - 1);
    endfunction

    task automatic model_reset();
        m_play  = 0;
        m_over  = 0;
        m_k     = 0;
        m_score = 0;
        m_level = 0;
        m_timer = 0;
    endtask

    task automatic model_edge(input bit s, input bit h, input bit m);
        bit tk;
        tk = m_tick();
        if (m_play) begin
            if (h && !m)
                m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
            else if (m && !h)
                m_score = (m_score > 0) ? m_score - 1 : 0;
            if (lvl_of(m_score) > m_level)
                m_level = lvl_of(m_score);
            if (tk)
                m_timer++;
            m_k++;
            if (m_timer == G) begin
                m_play = 0;
                m_over = 1;
            end
        end else if (s) begin
            m_play  = 1;
            m_over  = 0;
            m_k     = 0;
            m_score = 0;
            m_timer = 0;
            m_level = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".score"}, int'(score), m_score);
        chk({tag, ".level"}, int'(level), m_level);
        chk({tag, ".timer"}, int'(timer), m_timer);
        chk({tag, ".playing"}, int'(playing), int'(m_play));
        chk({tag, ".over"}, int'(game_over), int'(m_over));
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic cycle(input bit s, input bit h, input bit m, input string tag);
        start = s;
        hit   = h;
        miss  = m;
        #1;
        chk({tag, ".tick"}, int'(sec_tick), int'(m_tick()));
        @(posedge clk);
        model_edge(s, h, m);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        bit done;
        rst   = 1'b1;
        start = 1'b0;
        hit   = 1'b0;
        miss  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all("reset");

        for (int i = 0; i < 10; i++)
            cycle(0, 0, 0, "idle");
        chk("idle.score", int'(score), 0);
        chk("idle.level", int'(level), 0);

        cycle(1, 0, 0, "start");
        chk("start.playing", int'(playing), 1);
        chk("start.level", int'(level), 1);

        cycle(0, 0, 1, "miss0");
        chk("miss0.score", int'(score), 0);

        for (int i = 0; i < 25; i++)
            cycle(0, 1, 0, "hit25");
        chk("hit25.score", int'(score), 25);
        chk("hit25.level", int'(level), 2);

        for (int i = 0; i < 10; i++)
            cycle(0, 0, 1, "miss10");
        chk("miss10.score", int'(score), 15);
        chk("miss10.level", int'(level), 2);

        for (int i = 0; i < 105; i++)
            cycle(0, 1, 0, "hit105");
        chk("hit105.score", int'(score), 99);
        chk("hit105.level", int'(level), 3);

        cycle(0, 1, 1, "both");
        chk("both.score", int'(score), 99);

        cycle(0, 0, 1, "pre");
        cycle(0, 0, 1, "pre");

        done = 0;
        for (int i = 0; i < 4 * T * G && !done; i++) begin
            if (m_tick() && m_timer == G - 1)
                done = 1;
            else
                cycle(0, 0, 0, "wait");
        end
        chk("final.reached", int'(done), 1);

        cycle(0, 1, 0, "final");
        chk("final.score", int'(score), 98);
        chk("final.over", int'(game_over), 1);
        chk("final.timer", int'(timer), G);

        for (int i = 0; i < 3; i++)
            cycle(0, 1, 0, "frozen");
        chk("frozen.score", int'(score), 98);
        chk("over.tick", int'(sec_tick), 0);

        cycle(1, 0, 0, "restart");
        chk("restart.score", int'(score), 0);
        chk("restart.timer", int'(timer), 0);
        chk("restart.level", int'(level), 1);
        chk("restart.playing", int'(playing), 1);

        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 39) == 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 4) == 0,
                  "rand");

        cycle(1, 0, 0, "rst_pre");
        for (int i = 0; i < 3; i++)
            cycle(0, 1, 0, "rst_pre");
        chk("rst_pre.playing", int'(playing), 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.tick", int'(sec_tick), 0);
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 0, 0, "post_rst");
        cycle(1, 0, 0, "post_rst");
        for (int i = 0; i < 2 * T; i++)
            cycle(0, 1, 0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
